count_event_gen: RTL

- Front-end conditioner that drives the En/Slt inputs of the dual 64-bit event counter stage.
- Takes a raw, asynchronous, bouncy key input plus a raw channel-select level.
- Synchronises both, debounces the key, and emits exactly one single-cycle En pulse per clean press.
- Slt carries the registered channel select, so each physical press advances the downstream counter exactly once.

---
 rtl/count_event_gen_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/count_event_gen.sv | 126 ++++++++++++
 3 files changed

// File: rtl/count_event_gen_pkg.sv
// Shared types and defaults for the count_event_gen key conditioner.
// State encoding is fixed so downstream debug tooling can decode it directly.
package count_event_gen_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } ceg_state_e;

  localparam int DEF_DEB_CYCLES    = 4;
  localparam int DEF_DEB_W         = 8;
  localparam int DEF_REPEAT_DELAY  = 16;
  localparam int DEF_REPEAT_PERIOD = 4;

  localparam logic SYNC_RESET_VAL = 1'b0;

  // The debounced key level is high in both states that follow an accepted press.
  function automatic logic is_held(input ceg_state_e s);
    return (s == PRESSED) || (s == WAIT_RELEASE);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, synchronous reset.
module sync_2ff
  import count_event_gen_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta <= SYNC_RESET_VAL;
      q    <= SYNC_RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/count_event_gen.sv
// Key conditioner: synchronise, debounce, emit one En pulse per clean press with Slt.
// Define REPEAT_EN to add auto-repeat pulses while the key is held.
module count_event_gen
  import count_event_gen_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int DEB_W         = DEF_DEB_W,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic Clk,
  input  logic Reset,
  input  logic KeyIn,
  input  logic SelIn,
  output logic En,
  output logic Slt,
  output logic Pressed
);

`ifdef REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  // En is a valid-only strobe: one cycle per event, Slt qualifies it, no backpressure.
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] REP_LAST   = DEB_W'(REPEAT_DELAY - 1);
  localparam int               RELOAD_I   = (REPEAT_PERIOD >= REPEAT_DELAY) ? 0
                                          : (REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [DEB_W-1:0] REP_RELOAD = DEB_W'(RELOAD_I);

  ceg_state_e       state, state_n;
  logic [DEB_W-1:0] cnt, cnt_n;
  logic             en_n, slt_n;
  logic             key_s, sel_s;

  sync_2ff u_key_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (KeyIn),
    .q     (key_s)
  );

  sync_2ff u_sel_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (SelIn),
    .q     (sel_s)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    en_n    = 1'b0;
    slt_n   = Slt;
    case (state)
      IDLE: begin
        if (key_s) begin
          state_n = WAIT_PRESS;
          cnt_n   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!key_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = PRESSED;
          cnt_n   = '0;
          en_n    = 1'b1;
          slt_n   = sel_s;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!key_s) begin
          state_n = WAIT_RELEASE;
          cnt_n   = '0;
        end else if (REPEAT_ON) begin
          // Reloading to DELAY-PERIOD makes later pulses PERIOD cycles apart.
          if (cnt == REP_LAST) begin
            en_n  = 1'b1;
            slt_n = sel_s;
            cnt_n = REP_RELOAD;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      WAIT_RELEASE: begin
        if (key_s) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      En      <= 1'b0;
      Slt     <= 1'b0;
      Pressed <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      En      <= en_n;
      Slt     <= slt_n;
      Pressed <= is_held(state_n);
    end
  end

endmodule
